// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared definitions for the instruction-memory loader: the
//             loader state encoding and the width of the word-count header.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Word-count header carried in front of the image (two bytes, big-endian).
  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module   : byte_packer
//  Purpose  : Assembles four serial bytes into one 32-bit word, first byte
//             landing in bits 31:24.
//  Ports    : clk        - clock
//             rst        - asynchronous active-low reset
//             clear      - drop any partially assembled word
//             load       - byte_in is taken this cycle
//             byte_in    - incoming byte
//             word       - assembled word (held until the next load/clear)
//             word_full  - the byte taken this cycle completes a word
//  Revision : 1.0  initial release
// ============================================================================
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      shift_d = {shift_q[23:0], byte_in};
      cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word      = shift_q;
  assign word_full = load && !clear && (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Receives a program image over a byte stream (2-byte big-endian
//             word count followed by 4 bytes per word) and writes it into
//             instruction memory from address 0 while holding the CPU in
//             reset.
//  Ports    : clk         - clock
//             rst         - asynchronous active-low reset
//             start       - level-sampled load request (IDLE/ERR only)
//             byte_in     - serial-link byte
//             byte_valid  - byte_in valid
//             byte_ready  - loader accepts a byte this cycle
//             imem_we     - instruction-memory write strobe
//             imem_addr   - instruction-memory word address
//             imem_wdata  - instruction word
//             cpu_hold    - keep the CPU in reset while high
//             done        - one-cycle pulse on a successful load
//             error       - sticky error flag (bad count or timeout)
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]       MAX_WORDS = 32'(64'd1 << ADDR_W);

  loader_state_e      state_q, state_d;
  logic [HDR_W-1:0]   count_q, count_d;   // header, then words still to write
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               chk_q, chk_d;       // first DATA cycle: judge the count

  logic               accept;
  logic               tmo_expired;
  logic               packer_clear;
  logic               packer_load;
  logic               word_full;
  logic [31:0]        word;

  assign byte_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                      ((state_q == DATA) && !chk_q);
  assign accept      = byte_valid && byte_ready;
  assign packer_load = accept && (state_q == DATA);
  // The count stays registered for one cycle before it is compared so the
  // 16-bit range check never sits behind the byte_in input path.
  assign tmo_expired = byte_ready && !accept && (tmo_q == TMO_LAST);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (packer_clear),
    .load      (packer_load),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_d       = addr_q;
    tmo_d        = tmo_q;
    chk_d        = 1'b0;
    packer_clear = 1'b0;

    // Idle-gap counter runs only while a byte is being waited for.
    if (byte_ready) begin
      if (accept) tmo_d = '0;
      else        tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d      = HDR_HI;
          count_d      = '0;
          addr_d       = '0;
          tmo_d        = '0;
          packer_clear = 1'b1;  // discard bytes of an abandoned word
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d = {count_q[HDR_W-9:0], byte_in};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = {count_q[HDR_W-9:0], byte_in};
          state_d = DATA;
          chk_d   = 1'b1;
        end
      end
      DATA: begin
        if (chk_q) begin
          if (count_q == '0)                 state_d = DONE;
          else if (32'(count_q) > MAX_WORDS) state_d = ERR;
        end else if (word_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Address may wrap after the last slot; no write follows it.
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - HDR_W'(1);
        state_d = (count_q == HDR_W'(1)) ? DONE : DATA;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (tmo_expired) begin
      state_d = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      chk_q   <= chk_d;
    end
  end

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);  // ERR is left only through start
  assign cpu_hold   = (state_q != IDLE) && (state_q != DONE);

endmodule
`default_nettype wire
